tdm_demux1_4: RTL and testbench

TDM_DEMUX1_4 -- requirements
Module: tdm_demux1_4

---
 rtl/tdm_pkg.sv | 21 ++
 rtl/tdm_slot_counter.sv | 46 ++++
 rtl/tdm_demux1_4.sv | 139 +++++++++++++
 tb/tb_tdm_demux1_4.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// ============================================================================
// Module   : tdm_pkg
// Purpose  : Shared TDM constants and FSM state encoding (mux and demux).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdm_pkg;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    typedef logic [1:0] tdm_state_t;

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

endpackage : tdm_pkg

`default_nettype wire

// File: rtl/tdm_slot_counter.sv
// ============================================================================
// Module   : tdm_slot_counter
// Purpose  : TDM slot index with clear, load-to-one and wrapping increment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] slot_o
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    // Clear beats load beats increment; increment wraps naturally at SLOTS.
    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = SLOT_W'(1);
        end else if (inc_i) begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule : tdm_slot_counter

`default_nettype wire

// File: rtl/tdm_demux1_4.sv
// ============================================================================
// Module   : tdm_demux1_4
// Purpose  : 4-slot serial TDM demultiplexer with frame lock acquisition.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux1_4
    import tdm_pkg::*;
#(
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              y_in,
    input  logic              valid_in,
    input  logic              sync_in,
    output logic [SLOTS-1:0]  o,
    output logic              o_valid,
    output logic              locked,
    output logic              sync_err,
    output logic [SLOT_W-1:0] slot
);

    tdm_state_t        state_q,    state_d;
    logic [3:0]        good_q,     good_d;
    logic [2:0]        shadow_q,   shadow_d;
    logic [SLOTS-1:0]  o_q,        o_d;
    logic              o_valid_q,  o_valid_d;
    logic              locked_q;
    logic              sync_err_q, sync_err_d;

    logic              slot_clr;
    logic              slot_load1;
    logic              slot_inc;
    logic [SLOT_W-1:0] slot_w;
    logic [3:0]        good_inc_w;
    logic [SLOTS-1:0]  frame_w;

    tdm_slot_counter u_slot (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (slot_clr),
        .load1_i (slot_load1),
        .inc_i   (slot_inc),
        .slot_o  (slot_w)
    );

    assign good_inc_w = good_q + 4'd1;
    assign frame_w    = {y_in, shadow_q};

    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        shadow_d   = shadow_q;
        o_d        = o_q;
        o_valid_d  = 1'b0;
        sync_err_d = 1'b0;
        slot_clr   = 1'b0;
        slot_load1 = 1'b0;
        slot_inc   = 1'b0;

        if (valid_in) begin
            if (state_q == ST_HUNT) begin
                if (sync_in) begin
                    shadow_d[0] = y_in;
                    slot_load1  = 1'b1;
                    good_d      = 4'd0;
                    state_d     = ST_ACQ;
                end
            end else if (slot_w == '0) begin
                if (sync_in) begin
                    shadow_d[0] = y_in;
                    slot_load1  = 1'b1;
                end else begin
                    sync_err_d = 1'b1;
                    slot_clr   = 1'b1;
                    good_d     = 4'd0;
                    state_d    = ST_HUNT;
                end
            end else if (sync_in) begin
                // Misplaced marker: restart the frame on this beat.
                sync_err_d  = 1'b1;
                shadow_d[0] = y_in;
                slot_load1  = 1'b1;
                good_d      = 4'd0;
                state_d     = ST_ACQ;
            end else begin
                slot_inc = 1'b1;
                case (slot_w)
                    2'd1:    shadow_d[1] = y_in;
                    2'd2:    shadow_d[2] = y_in;
                    default: begin
                        if (state_q == ST_LOCK) begin
                            o_d       = frame_w;
                            o_valid_d = 1'b1;
                        end else begin
                            good_d = good_inc_w;
                            if (good_inc_w == 4'(LOCK_FRAMES)) begin
                                state_d   = ST_LOCK;
                                o_d       = frame_w;
                                o_valid_d = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            good_q     <= 4'd0;
            shadow_q   <= 3'd0;
            o_q        <= '0;
            o_valid_q  <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            shadow_q   <= shadow_d;
            o_q        <= o_d;
            o_valid_q  <= o_valid_d;
            locked_q   <= (state_d == ST_LOCK);
            sync_err_q <= sync_err_d;
        end
    end

    assign o        = o_q;
    assign o_valid  = o_valid_q;
    assign locked   = locked_q;
    assign sync_err = sync_err_q;
    assign slot     = slot_w;

endmodule : tdm_demux1_4

`default_nettype wire

// File: tb/tb_tdm_demux1_4.sv
// ============================================================================
// Module   : tb_tdm_demux1_4
// Purpose  : Directed self-checking bench for tdm_demux1_4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux1_4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       y_in = 1'b0;
    logic       valid_in = 1'b0;
    logic       sync_in = 1'b0;

    logic [3:0] o,  o1;
    logic       o_valid, o_valid1;
    logic       locked,  locked1;
    logic       sync_err, sync_err1;
    logic [1:0] slot, slot1;

    // Packed view: {o[3:0], o_valid, locked, sync_err, slot[1:0]}
    logic [8:0] obs, obs1;
    assign obs  = {o,  o_valid,  locked,  sync_err,  slot};
    assign obs1 = {o1, o_valid1, locked1, sync_err1, slot1};

    integer total = 0;
    integer bad   = 0;

    always #5 clk = ~clk;

    tdm_demux1_4 #(.LOCK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .valid_in(valid_in), .sync_in(sync_in),
        .o(o), .o_valid(o_valid), .locked(locked), .sync_err(sync_err), .slot(slot)
    );

    tdm_demux1_4 #(.LOCK_FRAMES(1)) dut1 (
        .clk(clk), .rst(rst), .y_in(y_in), .valid_in(valid_in), .sync_in(sync_in),
        .o(o1), .o_valid(o_valid1), .locked(locked1), .sync_err(sync_err1), .slot(slot1)
    );

    task automatic beat(input logic v, input logic s, input logic y);
        valid_in = v;
        sync_in  = s;
        y_in     = y;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        sync_in  = 1'b0;
        y_in     = 1'b0;
    endtask

    // f[k] is the channel-k bit; sync accompanies slot 0.
    task automatic send_frame(input logic [3:0] f);
        for (int k = 0; k < 4; k++) begin
            beat(1'b1, (k == 0), f[k]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        beat(1'b1, 1'b1, 1'b1);
        total++;
        if (obs !== 9'b0000_0_0_0_00) begin
            bad++; $display("FAIL reset_state got %b want %b", obs, 9'b0000_0_0_0_00);
        end
        rst = 1'b0;
        beat(1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== 9'b0000_0_0_0_00) begin
            bad++; $display("FAIL hunt_discard got %b want %b", obs, 9'b0000_0_0_0_00);
        end
    endtask

    task automatic test_acquire;
        beat(1'b1, 1'b1, 1'b1);
        total++;
        if (obs !== 9'b0000_0_0_0_01) begin
            bad++; $display("FAIL acq_first_beat got %b want %b", obs, 9'b0000_0_0_0_01);
        end
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== 9'b0000_0_0_0_00) begin
            bad++; $display("FAIL acq_frame1_unpub got %b want %b", obs, 9'b0000_0_0_0_00);
        end
        send_frame(4'b0110);
        total++;
        if (obs !== 9'b0110_1_1_0_00) begin
            bad++; $display("FAIL acq_frame2_lock got %b want %b", obs, 9'b0110_1_1_0_00);
        end
        beat(1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== 9'b0110_0_1_0_00) begin
            bad++; $display("FAIL acq_pulse_end got %b want %b", obs, 9'b0110_0_1_0_00);
        end
    endtask

    task automatic test_valid_gap;
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== 9'b0110_0_1_0_10) begin
            bad++; $display("FAIL gap_slot2 got %b want %b", obs, 9'b0110_0_1_0_10);
        end
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, 1'b0, 1'b1);
            total++;
            if (obs !== 9'b0110_0_1_0_10) begin
                bad++; $display("FAIL gap_hold%0d got %b want %b", i, obs, 9'b0110_0_1_0_10);
            end
        end
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        total++;
        if (obs !== 9'b0011_1_1_0_00) begin
            bad++; $display("FAIL gap_publish got %b want %b", obs, 9'b0011_1_1_0_00);
        end
        beat(1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== 9'b0011_0_1_0_00) begin
            bad++; $display("FAIL gap_single_pulse got %b want %b", obs, 9'b0011_0_1_0_00);
        end
    endtask

    task automatic test_slot0_nosync;
        beat(1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== 9'b0011_0_0_1_00) begin
            bad++; $display("FAIL nosync_err got %b want %b", obs, 9'b0011_0_0_1_00);
        end
        beat(1'b0, 1'b0, 1'b0);
        total++;
        if (obs !== 9'b0011_0_0_0_00) begin
            bad++; $display("FAIL nosync_err_end got %b want %b", obs, 9'b0011_0_0_0_00);
        end
    endtask

    task automatic test_midframe_sync;
        send_frame(4'b1010);
        total++;
        if (obs !== 9'b0011_0_0_0_00) begin
            bad++; $display("FAIL relock_f1 got %b want %b", obs, 9'b0011_0_0_0_00);
        end
        send_frame(4'b0101);
        total++;
        if (obs !== 9'b0101_1_1_0_00) begin
            bad++; $display("FAIL relock_f2 got %b want %b", obs, 9'b0101_1_1_0_00);
        end
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 1'b1);
        total++;
        if (obs !== 9'b0101_0_0_1_01) begin
            bad++; $display("FAIL midsync_err got %b want %b", obs, 9'b0101_0_0_1_01);
        end
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== 9'b0101_0_0_0_00) begin
            bad++; $display("FAIL midsync_frame_unpub got %b want %b", obs, 9'b0101_0_0_0_00);
        end
        send_frame(4'b0011);
        total++;
        if (obs !== 9'b0011_1_1_0_00) begin
            bad++; $display("FAIL midsync_relock got %b want %b", obs, 9'b0011_1_1_0_00);
        end
    endtask

    task automatic test_reset_midframe;
        beat(1'b1, 1'b1, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        total++;
        if (obs !== 9'b0011_0_1_0_10) begin
            bad++; $display("FAIL rstmid_pre got %b want %b", obs, 9'b0011_0_1_0_10);
        end
        rst = 1'b1;
        beat(1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== 9'b0000_0_0_0_00) begin
            bad++; $display("FAIL rstmid_clear got %b want %b", obs, 9'b0000_0_0_0_00);
        end
        rst = 1'b0;
        beat(1'b1, 1'b1, 1'b0);
        total++;
        if (obs !== 9'b0000_0_0_0_01) begin
            bad++; $display("FAIL rstmid_restart got %b want %b", obs, 9'b0000_0_0_0_01);
        end
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        total++;
        if (obs !== 9'b0000_0_0_0_00) begin
            bad++; $display("FAIL rstmid_f1 got %b want %b", obs, 9'b0000_0_0_0_00);
        end
        send_frame(4'b1001);
        total++;
        if (obs !== 9'b1001_1_1_0_00) begin
            bad++; $display("FAIL rstmid_f2 got %b want %b", obs, 9'b1001_1_1_0_00);
        end
    endtask

    task automatic test_lock1;
        rst = 1'b1;
        beat(1'b0, 1'b0, 1'b0);
        total++;
        if (obs1 !== 9'b0000_0_0_0_00) begin
            bad++; $display("FAIL lock1_reset got %b want %b", obs1, 9'b0000_0_0_0_00);
        end
        rst = 1'b0;
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        total++;
        if (obs1 !== 9'b0000_0_0_0_11) begin
            bad++; $display("FAIL lock1_pre got %b want %b", obs1, 9'b0000_0_0_0_11);
        end
        beat(1'b1, 1'b0, 1'b1);
        total++;
        if (obs1 !== 9'b1000_1_1_0_00) begin
            bad++; $display("FAIL lock1_publish got %b want %b", obs1, 9'b1000_1_1_0_00);
        end
        beat(1'b0, 1'b0, 1'b0);
        total++;
        if (obs1 !== 9'b1000_0_1_0_00) begin
            bad++; $display("FAIL lock1_pulse_end got %b want %b", obs1, 9'b1000_0_1_0_00);
        end
    endtask

    initial begin
        test_reset;
        test_acquire;
        test_valid_gap;
        test_slot0_nosync;
        test_midframe_sync;
        test_reset_midframe;
        test_lock1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tdm_demux1_4

`default_nettype wire
